// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// The result is computed when the op is accepted and committed to hi/lo when the busy count expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              finish;
    logic              op_is_md;
    logic [63:0]       res;
    logic [31:0]       hi_n;
    logic [31:0]       lo_n;
    logic              write_n;

    // Low 64 bits of the product of the extended operands give both signed and unsigned results.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return p;
    endfunction

    // Returns {remainder, quotient}; overflow and zero-divisor cases are pinned explicitly.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign op_is_md = start & ~md_op[2];
    assign busy     = (state == BUSY);
    assign stall_md = md_use_D & (busy | op_is_md);

    always_comb begin
        res = md_op[1] ? div64(rs_val, rt_val, ~md_op[0]) : mul64(rs_val, rt_val, ~md_op[0]);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (op_is_md) begin
                    state_next = BUSY;
                    accept     = 1'b1;
                end
            end
            BUSY: begin
                if (count == CNT_W'(1)) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                count <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (state == BUSY) begin
                count <= count - CNT_W'(1);
            end
            if (finish && write_n) begin
                hi <= hi_n;
                lo <= lo_n;
            end else if (state == IDLE && start && md_op == 3'd4) begin
                hi <= rs_val;
            end else if (state == IDLE && start && md_op == 3'd5) begin
                lo <= rs_val;
            end
        end
    end

    // Pending result: only consumed on finish, which always follows an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            hi_n    <= res[63:32];
            lo_n    <= res[31:0];
            write_n <= ~(md_op[1] && rt_val == 32'd0);
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of ops with hand-computed hi/lo/latency plus corner sequences.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic viol_seen = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Protocol monitor: flags any start presented while the unit is busy.
    always @(posedge clk) begin
        if (reset === 1'b1 && start === 1'b1 && busy === 1'b1) viol_seen <= 1'b1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (busy === 1'b1 && lat < 50) begin
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  lat;
        logic bad;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd3, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 10};
        vecs[4]  = '{3'd4, 32'h11,        32'd0,        32'h0000_0011, 32'h0000_0003, 0};
        vecs[5]  = '{3'd5, 32'h22,        32'd0,        32'h0000_0011, 32'h0000_0022, 0};
        vecs[6]  = '{3'd2, 32'd5,         32'd0,        32'h0000_0011, 32'h0000_0022, 10};
        vecs[7]  = '{3'd3, 32'd5,         32'd0,        32'h0000_0011, 32'h0000_0022, 10};
        vecs[8]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[9]  = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[10] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[11] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[12] = '{3'd6, 32'hDEAD,      32'hBEEF,     32'h0000_0001, 32'hFFFF_FFFD, 0};

        reset    = 1'b0;
        start    = 1'b0;
        md_op    = 3'd0;
        rs_val   = '0;
        rt_val   = '0;
        md_use_D = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_stall", 64'(stall_md), 64'd0);
        reset    = 1'b1;
        md_use_D = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
        end

        // Stall follows md_use_D through the start cycle and every busy cycle.
        md_use_D = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd2;
        rs_val = 32'd9;
        rt_val = 32'd3;
        #1 check("stall_start_cycle", 64'(stall_md), 64'd1);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bad   = 1'b0;
        while (busy === 1'b1 && lat < 50) begin
            if (stall_md !== 1'b1) bad = 1'b1;
            lat++;
            @(negedge clk);
        end
        check("stall_during_busy", 64'(bad), 64'd0);
        check("stall_busy_latency", 64'(lat), 64'd10);
        check("stall_after_busy", 64'(stall_md), 64'd0);
        check("div9_3_lo", 64'(lo), 64'd3);
        check("div9_3_hi", 64'(hi), 64'd0);

        md_use_D = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        rs_val = 32'd8;
        rt_val = 32'd3;
        #1 bad = stall_md;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (busy === 1'b1 && lat < 50) begin
            if (stall_md !== 1'b0) bad = 1'b1;
            lat++;
            @(negedge clk);
        end
        check("no_use_no_stall", 64'(bad), 64'd0);
        check("div8_3_hilo", {hi, lo}, {32'd2, 32'd2});

        // A start pulse while busy must not disturb the count or the result.
        check("no_violation_yet", 64'(viol_seen), 64'd0);
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd2;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (busy === 1'b1 && lat < 50) begin
            lat++;
            start  = (lat == 2);
            md_op  = 3'd0;
            rs_val = 32'd5;
            rt_val = 32'd5;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_latency", 64'(lat), 64'd10);
        check("busy_start_hilo", {hi, lo}, {32'd2, 32'd14});
        check("busy_start_flagged", 64'(viol_seen), 64'd1);

        // Asynchronous reset two cycles into a mult.
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd0;
        rs_val = 32'd6;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bad   = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
        end
        check("after_reset_quiet", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
